tb_cmd_sequencer: RTL and testbench

- Initiator side of the testbench command interface: steps through a small command memory and presents one command at a time (opcode + argument + valid) to the command decoder.
- Holds each command until the decoder acknowledges, then advances.
- Supervises each command with an ack-timeout; reports done, busy and error status to the top-level bench.
- Sits between the scenario loader (writes the command memory) and the decoder/SET/WAIT/CHECK collars.

---
 rtl/tb_cmd_sequencer.sv | 153 +++++++++++++++
 tb/tb_tb_cmd_sequencer.sv | 387 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tb_cmd_sequencer.sv
// Command sequencer for the bench command interface. It walks a small command memory and
// presents one opcode/argument at a time, holding each until acked. It reports done, busy and error.
module tb_cmd_sequencer #(
  parameter int DEPTH   = 16,
  parameter int ARG_W   = 16,
  parameter int TIMEOUT = 1000,
  parameter int CNT_W   = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_wr_en,
  input  logic [$clog2(DEPTH)-1:0] i_wr_addr,
  input  logic [3+ARG_W-1:0]       i_wr_data,
  input  logic                     i_start,
  input  logic                     i_ack,
  output logic [2:0]               o_cmd_op,
  output logic [ARG_W-1:0]         o_cmd_arg,
  output logic                     o_cmd_valid,
  output logic [$clog2(DEPTH)-1:0] o_pc,
  output logic                     o_busy,
  output logic                     o_done,
  output logic                     o_err_timeout,
  output logic                     o_err_op,
  output logic [CNT_W-1:0]         o_issued_cnt,
  output logic [2:0]               o_dbg_state
);

  // Handshake: a command is transferred on any rising edge where o_cmd_valid and i_ack are both 1;
  // op/arg stay stable while o_cmd_valid is high, and valid drops on the cycle after the transfer.

  localparam int AW = $clog2(DEPTH);
  localparam int TO_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
  localparam logic [AW-1:0] LAST_PC = AW'(DEPTH - 1);

  localparam logic [2:0] OP_NOP = 3'd0;
  localparam logic [2:0] OP_RS5 = 3'd5;
  localparam logic [2:0] OP_RS6 = 3'd6;
  localparam logic [2:0] OP_END = 3'd7;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_ISSUE = 3'd2,
    S_DONE  = 3'd3,
    S_ERROR = 3'd4
  } state_t;

  state_t               state;
  logic [2+ARG_W:0]     mem [DEPTH];
  logic [2+ARG_W:0]     f_slot;
  logic [2:0]           f_op;
  logic [ARG_W-1:0]     f_arg;
  logic [TO_W-1:0]      to_cnt;
  logic                 idle_like;

  assign idle_like   = (state == S_IDLE) || (state == S_DONE) || (state == S_ERROR);
  assign f_slot      = mem[o_pc];
  assign f_op        = f_slot[2+ARG_W -: 3];
  assign f_arg       = f_slot[ARG_W-1:0];
  assign o_dbg_state = state;

  // Memory is never cleared by reset so a scenario can be replayed after an abort.
  always_ff @(posedge clk) begin
    if (i_wr_en && idle_like) begin
      mem[i_wr_addr] <= i_wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= S_IDLE;
      o_cmd_op      <= OP_NOP;
      o_cmd_arg     <= '0;
      o_cmd_valid   <= 1'b0;
      o_pc          <= '0;
      o_busy        <= 1'b0;
      o_done        <= 1'b0;
      o_err_timeout <= 1'b0;
      o_err_op      <= 1'b0;
      o_issued_cnt  <= '0;
      to_cnt        <= '0;
    end else begin
      case (state)
        S_IDLE, S_DONE, S_ERROR: begin
          if (i_start) begin
            state         <= S_FETCH;
            o_pc          <= '0;
            o_issued_cnt  <= '0;
            o_done        <= 1'b0;
            o_err_timeout <= 1'b0;
            o_err_op      <= 1'b0;
            o_busy        <= 1'b1;
          end
        end
        S_FETCH: begin
          o_cmd_op  <= f_op;
          o_cmd_arg <= f_arg;
          if (f_op == OP_NOP) begin
            if (o_pc == LAST_PC) begin
              state  <= S_DONE;
              o_done <= 1'b1;
              o_busy <= 1'b0;
            end else begin
              o_pc <= o_pc + 1'b1;
            end
          end else if (f_op == OP_END) begin
            state  <= S_DONE;
            o_done <= 1'b1;
            o_busy <= 1'b0;
          end else if (f_op == OP_RS5 || f_op == OP_RS6) begin
            state    <= S_ERROR;
            o_err_op <= 1'b1;
            o_busy   <= 1'b0;
          end else begin
            state       <= S_ISSUE;
            o_cmd_valid <= 1'b1;
            to_cnt      <= '0;
          end
        end
        S_ISSUE: begin
          // Ack is checked first so it wins over a timeout expiring in the same cycle.
          if (i_ack) begin
            o_cmd_valid <= 1'b0;
            to_cnt      <= '0;
            if (o_issued_cnt != {CNT_W{1'b1}}) begin
              o_issued_cnt <= o_issued_cnt + 1'b1;
            end
            if (o_pc == LAST_PC) begin
              state  <= S_DONE;
              o_done <= 1'b1;
              o_busy <= 1'b0;
            end else begin
              state <= S_FETCH;
              o_pc  <= o_pc + 1'b1;
            end
          end else if ((TIMEOUT != 0) && (to_cnt == TO_LAST)) begin
            state         <= S_ERROR;
            o_err_timeout <= 1'b1;
            o_cmd_valid   <= 1'b0;
            o_busy        <= 1'b0;
          end else begin
            to_cnt <= to_cnt + 1'b1;
          end
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_tb_cmd_sequencer.sv
// Bench for tb_cmd_sequencer: directed timing scenarios plus randomized programs checked
// against a behavioural walk of the command memory. A second instance has a short timeout and narrow counter.
module tb_tb_cmd_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_wr_en;
  logic [3:0]  i_wr_addr;
  logic [18:0] i_wr_data;
  logic        i_start;
  logic        i_ack;

  logic [2:0]  o_cmd_op;
  logic [15:0] o_cmd_arg;
  logic        o_cmd_valid;
  logic [3:0]  o_pc;
  logic        o_busy, o_done, o_err_timeout, o_err_op;
  logic [15:0] o_issued_cnt;
  logic [2:0]  o_dbg_state;

  logic [2:0]  t_cmd_op;
  logic [15:0] t_cmd_arg;
  logic        t_cmd_valid;
  logic [3:0]  t_pc;
  logic        t_busy, t_done, t_err_timeout, t_err_op;
  logic [1:0]  t_issued_cnt;
  logic [2:0]  t_dbg_state;

  int total = 0;
  int bad = 0;

  logic [2:0]  m_op  [16];
  logic [15:0] m_arg [16];
  logic [22:0] exp_q [$];

  tb_cmd_sequencer dut (
    .clk(clk), .rst(rst), .i_wr_en(i_wr_en), .i_wr_addr(i_wr_addr), .i_wr_data(i_wr_data),
    .i_start(i_start), .i_ack(i_ack), .o_cmd_op(o_cmd_op), .o_cmd_arg(o_cmd_arg),
    .o_cmd_valid(o_cmd_valid), .o_pc(o_pc), .o_busy(o_busy), .o_done(o_done),
    .o_err_timeout(o_err_timeout), .o_err_op(o_err_op), .o_issued_cnt(o_issued_cnt),
    .o_dbg_state(o_dbg_state)
  );

  tb_cmd_sequencer #(.TIMEOUT(4), .CNT_W(2)) dut_to (
    .clk(clk), .rst(rst), .i_wr_en(i_wr_en), .i_wr_addr(i_wr_addr), .i_wr_data(i_wr_data),
    .i_start(i_start), .i_ack(i_ack), .o_cmd_op(t_cmd_op), .o_cmd_arg(t_cmd_arg),
    .o_cmd_valid(t_cmd_valid), .o_pc(t_pc), .o_busy(t_busy), .o_done(t_done),
    .o_err_timeout(t_err_timeout), .o_err_op(t_err_op), .o_issued_cnt(t_issued_cnt),
    .o_dbg_state(t_dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog got=expired exp=finish");
    $fatal(1, "watchdog");
  end

  // driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; i_start = 1'b0; i_ack = 1'b0; i_wr_en = 1'b0;
    i_wr_addr = '0; i_wr_data = '0;
    step();
    rst = 1'b0;
  endtask

  task automatic wr(input int a, input logic [2:0] op, input logic [15:0] arg);
    i_wr_en = 1'b1; i_wr_addr = 4'(a); i_wr_data = {op, arg};
    m_op[a] = op; m_arg[a] = arg;
    step();
    i_wr_en = 1'b0;
  endtask

  // Walks the program from slot 0, queues every command that should be issued, then drives
  // random ack delays and checks each transfer and the final status.
  task automatic run_and_check(input string name, input int max_wait);
    int pc, cyc, wait_left, e_cnt;
    bit e_done, e_err;
    logic [22:0] item;
    exp_q.delete();
    pc = 0; e_cnt = 0; e_done = 0; e_err = 0;
    while (1) begin
      if (m_op[pc] == 3'd7) begin e_done = 1; break; end
      if (m_op[pc] == 3'd5 || m_op[pc] == 3'd6) begin e_err = 1; break; end
      if (m_op[pc] != 3'd0) begin
        exp_q.push_back({4'(pc), m_op[pc], m_arg[pc]});
        e_cnt++;
      end
      if (pc == 15) begin e_done = 1; break; end
      pc++;
    end
    i_ack = 1'b0; i_start = 1'b1;
    step();
    i_start = 1'b0;
    wait_left = $urandom_range(0, max_wait);
    cyc = 0;
    while (o_busy && cyc < 600) begin
      i_ack = 1'b0;
      if (o_cmd_valid) begin
        if (wait_left == 0) begin
          i_ack = 1'b1;
          wait_left = $urandom_range(0, max_wait);
          total++;
          if (exp_q.size() == 0) begin
            bad++;
            $display("FAIL %s_extra_cmd got=%0h exp=none", name, {o_pc, o_cmd_op, o_cmd_arg});
          end else begin
            item = exp_q.pop_front();
            if ({o_pc, o_cmd_op, o_cmd_arg} !== item) begin
              bad++;
              $display("FAIL %s_cmd got=%0h exp=%0h", name, {o_pc, o_cmd_op, o_cmd_arg}, item);
            end
          end
        end else begin
          wait_left--;
        end
      end
      step();
      cyc++;
    end
    i_ack = 1'b0;
    total++;
    if (cyc >= 600) begin
      bad++;
      $display("FAIL %s_budget got=%0d exp=<600", name, cyc);
    end
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL %s_missing got=%0d exp=0", name, exp_q.size());
    end
    total++;
    if ({o_done, o_err_op, o_err_timeout, o_busy, o_pc, o_issued_cnt} !==
        {e_done, e_err, 1'b0, 1'b0, 4'(pc), 16'(e_cnt)}) begin
      bad++;
      $display("FAIL %s_status got=%0h exp=%0h", name,
               {o_done, o_err_op, o_err_timeout, o_busy, o_pc, o_issued_cnt},
               {e_done, e_err, 1'b0, 1'b0, 4'(pc), 16'(e_cnt)});
    end
  endtask

  task automatic test_reset();
    do_reset();
    total++;
    if ({o_cmd_op, o_cmd_arg, o_cmd_valid, o_pc, o_busy, o_done, o_err_timeout, o_err_op,
         o_issued_cnt, o_dbg_state} !== 47'd0) begin
      bad++;
      $display("FAIL reset_outputs got=%0h exp=0", {o_cmd_op, o_cmd_arg, o_cmd_valid, o_pc,
               o_busy, o_done, o_err_timeout, o_err_op, o_issued_cnt});
    end
  endtask

  task automatic test_basic();
    logic [6:0] vpat;
    vpat = 7'b0010100;
    do_reset();
    wr(0, 3'd1, 16'h0012); wr(1, 3'd4, 16'h0034); wr(2, 3'd7, 16'h0000);
    i_start = 1'b1; i_ack = 1'b1;
    step();
    i_start = 1'b0;
    for (int c = 1; c <= 6; c++) begin
      if (c > 1) step();
      total++;
      if (o_cmd_valid !== vpat[c]) begin
        bad++;
        $display("FAIL basic_valid_c%0d got=%0b exp=%0b", c, o_cmd_valid, vpat[c]);
      end
      if (c == 2 || c == 4) begin
        total++;
        if ({o_pc, o_cmd_op, o_cmd_arg} !== ((c == 2) ? {4'd0, 3'd1, 16'h0012} : {4'd1, 3'd4, 16'h0034})) begin
          bad++;
          $display("FAIL basic_cmd_c%0d got=%0h", c, {o_pc, o_cmd_op, o_cmd_arg});
        end
      end
    end
    i_ack = 1'b0;
    total++;
    if ({o_done, o_busy, o_issued_cnt, o_pc} !== {1'b1, 1'b0, 16'd2, 4'd2}) begin
      bad++;
      $display("FAIL basic_final got=%0h exp=%0h", {o_done, o_busy, o_issued_cnt, o_pc},
               {1'b1, 1'b0, 16'd2, 4'd2});
    end
  endtask

  task automatic test_hold_ack();
    int n_valid;
    do_reset();
    wr(0, 3'd2, 16'h0005); wr(1, 3'd7, 16'h0000);
    i_start = 1'b1; i_ack = 1'b0;
    step();
    i_start = 1'b0;
    n_valid = 0;
    for (int c = 0; c < 20; c++) begin
      step();
      i_ack = 1'b0;
      if (o_cmd_valid) begin
        n_valid++;
        total++;
        if ({o_cmd_op, o_cmd_arg} !== {3'd2, 16'h0005}) begin
          bad++;
          $display("FAIL hold_stable got=%0h exp=%0h", {o_cmd_op, o_cmd_arg}, {3'd2, 16'h0005});
        end
        if (n_valid == 8) i_ack = 1'b1;
      end
      if (!o_busy) break;
    end
    total++;
    if (n_valid != 8) begin
      bad++;
      $display("FAIL hold_len got=%0d exp=8", n_valid);
    end
    total++;
    if ({o_done, o_err_timeout, o_issued_cnt} !== {1'b1, 1'b0, 16'd1}) begin
      bad++;
      $display("FAIL hold_final got=%0h exp=%0h", {o_done, o_err_timeout, o_issued_cnt},
               {1'b1, 1'b0, 16'd1});
    end
  endtask

  task automatic test_timeout();
    int n;
    do_reset();
    wr(0, 3'd3, 16'h00AB); wr(1, 3'd7, 16'h0000);
    i_start = 1'b1; i_ack = 1'b0;
    step();
    i_start = 1'b0;
    n = 0;
    for (int c = 0; c < 12; c++) begin
      step();
      if (t_cmd_valid) n++;
      if (!t_busy) break;
    end
    total++;
    if (n != 4) begin
      bad++;
      $display("FAIL timeout_len got=%0d exp=4", n);
    end
    total++;
    if ({t_err_timeout, t_cmd_valid, t_pc, t_busy, t_done} !== {1'b1, 1'b0, 4'd0, 1'b0, 1'b0}) begin
      bad++;
      $display("FAIL timeout_status got=%0h exp=%0h", {t_err_timeout, t_cmd_valid, t_pc, t_busy, t_done},
               {1'b1, 1'b0, 4'd0, 1'b0, 1'b0});
    end
    i_start = 1'b1;
    step();
    i_start = 1'b0;
    total++;
    if ({t_err_timeout, t_busy} !== 2'b01) begin
      bad++;
      $display("FAIL timeout_clear got=%0b exp=01", {t_err_timeout, t_busy});
    end
    // ack in the very cycle the timeout would expire
    n = 0;
    for (int c = 0; c < 12; c++) begin
      step();
      i_ack = 1'b0;
      if (t_cmd_valid) begin
        n++;
        if (n == 4) i_ack = 1'b1;
      end
      if (!t_busy) break;
    end
    i_ack = 1'b0;
    total++;
    if ({t_done, t_err_timeout, t_issued_cnt} !== {1'b1, 1'b0, 2'd1}) begin
      bad++;
      $display("FAIL timeout_ack_wins got=%0h exp=%0h", {t_done, t_err_timeout, t_issued_cnt},
               {1'b1, 1'b0, 2'd1});
    end
  endtask

  task automatic test_nop();
    int first;
    logic [15:0] first_arg;
    do_reset();
    wr(0, 3'd0, 16'h0000); wr(1, 3'd0, 16'h1111); wr(2, 3'd1, 16'hBEEF); wr(3, 3'd1, 16'h7777);
    // END lands in slot 3 in the same cycle as the start
    i_wr_en = 1'b1; i_wr_addr = 4'd3; i_wr_data = {3'd7, 16'h0000};
    m_op[3] = 3'd7; m_arg[3] = 16'h0000;
    i_start = 1'b1; i_ack = 1'b1;
    step();
    i_start = 1'b0; i_wr_en = 1'b0;
    first = -1; first_arg = '0;
    for (int c = 1; c <= 8; c++) begin
      if (c > 1) step();
      if (o_cmd_valid && first < 0) begin first = c; first_arg = o_cmd_arg; end
    end
    i_ack = 1'b0;
    total++;
    if (first != 4 || first_arg !== 16'hBEEF) begin
      bad++;
      $display("FAIL nop_first got=c%0d/%0h exp=c4/beef", first, first_arg);
    end
    total++;
    if ({o_done, o_issued_cnt} !== {1'b1, 16'd1}) begin
      bad++;
      $display("FAIL nop_final got=%0h exp=%0h", {o_done, o_issued_cnt}, {1'b1, 16'd1});
    end
  endtask

  task automatic test_full();
    do_reset();
    for (int i = 0; i < 16; i++) wr(i, 3'd1, 16'(i * 3 + 1));
    run_and_check("full", 0);
    total++;
    if ({t_done, t_issued_cnt} !== {1'b1, 2'd3}) begin
      bad++;
      $display("FAIL full_sat got=%0h exp=%0h", {t_done, t_issued_cnt}, {1'b1, 2'd3});
    end
    wr(5, 3'd6, 16'h0000);
    run_and_check("bad_op", 0);
  endtask

  task automatic test_reset_mid();
    int cyc;
    do_reset();
    for (int i = 0; i < 4; i++) wr(i, 3'd1, 16'(16'h0100 + i));
    wr(4, 3'd7, 16'h0000);
    i_start = 1'b1; i_ack = 1'b1;
    step();
    i_start = 1'b0;
    cyc = 0;
    while (!(o_cmd_valid && o_pc == 4'd3) && cyc < 40) begin step(); cyc++; end
    rst = 1'b1;
    step();
    rst = 1'b0; i_ack = 1'b0;
    total++;
    if ({o_cmd_op, o_cmd_arg, o_cmd_valid, o_pc, o_busy, o_done, o_err_timeout, o_err_op,
         o_issued_cnt} !== 44'd0 || cyc >= 40) begin
      bad++;
      $display("FAIL reset_mid got=%0h exp=0 cyc=%0d", {o_cmd_op, o_cmd_arg, o_cmd_valid, o_pc,
               o_busy, o_done, o_err_timeout, o_err_op, o_issued_cnt}, cyc);
    end
    // write attempted while busy must not reach the memory
    i_start = 1'b1;
    step();
    i_start = 1'b0;
    i_wr_en = 1'b1; i_wr_addr = 4'd1; i_wr_data = {3'd4, 16'hAAAA};
    step();
    i_wr_en = 1'b0;
    do_reset();
    run_and_check("replay", 2);
  endtask

  task automatic test_random();
    int r;
    logic [2:0] op;
    for (int it = 0; it < 12; it++) begin
      for (int s = 0; s < 16; s++) begin
        r = $urandom_range(0, 19);
        if (r < 3) op = 3'd0;
        else if (r < 7) op = 3'd1;
        else if (r < 10) op = 3'd2;
        else if (r < 13) op = 3'd3;
        else if (r < 16) op = 3'd4;
        else if (r < 18) op = 3'd7;
        else if (r == 18) op = ($urandom_range(0, 1) == 0) ? 3'd5 : 3'd6;
        else op = 3'd1;
        wr(s, op, 16'($urandom));
      end
      run_and_check("rand", 4);
    end
  endtask

  initial begin
    rst = 1'b1; i_wr_en = 1'b0; i_wr_addr = '0; i_wr_data = '0; i_start = 1'b0; i_ack = 1'b0;
    step();
    test_reset();
    test_basic();
    test_hold_ack();
    test_timeout();
    test_nop();
    test_full();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
